// File: rtl/radix_2_intt_stage_ctrl_pkg.sv
// Shared constants and state encoding for the radix-2 INTT stage sequencer.
// The butterfly PE is also parameterised from these defaults.
package radix_2_intt_stage_ctrl_pkg;

    localparam int N_DEF       = 17;
    localparam int Q_DEF       = 65537;
    localparam int TWOINV_DEF  = 32769;
    localparam int LOG_LEN_DEF = 4;
    localparam int SW_DEF      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Out-of-range stage requests fall back to the last (widest) stage.
    function automatic int unsigned clamp_stage(input int unsigned s, input int unsigned log_len);
        return (s >= log_len) ? (log_len - 1) : s;
    endfunction

endpackage

// File: rtl/radix_2_intt_stage_ctrl_if.sv
// Control, memory-read and write-back bundle of the INTT stage sequencer.
// The sequencer uses the master view; memories and the caller use the slave view.
interface radix_2_intt_stage_ctrl_if
    import radix_2_intt_stage_ctrl_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int LOG_LEN = LOG_LEN_DEF,
    parameter int SW      = SW_DEF
);

    logic               start;
    logic [SW-1:0]      stage;
    logic               busy;
    logic               done;
    logic [LOG_LEN-1:0] rd_addr_a;
    logic [LOG_LEN-1:0] rd_addr_b;
    logic [N-1:0]       rd_data_a;
    logic [N-1:0]       rd_data_b;
    logic [LOG_LEN-2:0] tw_addr;
    logic [N-1:0]       tw_data;
    logic               wr_en;
    logic [LOG_LEN-1:0] wr_addr_a;
    logic [LOG_LEN-1:0] wr_addr_b;
    logic [N-1:0]       wr_data_a;
    logic [N-1:0]       wr_data_b;

    modport master (
        input  start, stage, rd_data_a, rd_data_b, tw_data,
        output busy, done, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
    );

    modport slave (
        output start, stage, rd_data_a, rd_data_b, tw_data,
        input  busy, done, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
    );

endinterface

// File: rtl/radix_2_intt_pe.sv
// Combinational Gentleman-Sande butterfly with halving:
// a' = (a+b)/2 mod Q, b' = (a-b)*w/2 mod Q.
module radix_2_intt_pe
    import radix_2_intt_stage_ctrl_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int Q      = Q_DEF,
    parameter int TWOINV = TWOINV_DEF
) (
    input  logic [N-1:0] an,
    input  logic [N-1:0] bn,
    input  logic [N-1:0] tf,
    output logic [N-1:0] a_out,
    output logic [N-1:0] b_out
);

    localparam int W = 2 * N + 2;

    logic [W-1:0] sum_red;
    logic [W-1:0] diff_red;
    logic [W-1:0] tf_red;
    logic [W-1:0] prod_red;
    logic [W-1:0] a_full;
    logic [W-1:0] b_full;

    // Raw memory words may exceed Q, so every operand is reduced before use;
    // adding 2Q keeps the difference non-negative for any N-bit b.
    always_comb begin
        sum_red  = (W'(an) + W'(bn)) % W'(Q);
        diff_red = (W'(an) + W'(2 * Q) - W'(bn)) % W'(Q);
        tf_red   = W'(tf) % W'(Q);
        prod_red = (diff_red * tf_red) % W'(Q);
        a_full   = (sum_red * W'(TWOINV)) % W'(Q);
        b_full   = (prod_red * W'(TWOINV)) % W'(Q);
        a_out    = N'(a_full);
        b_out    = N'(b_full);
    end

endmodule

// File: rtl/radix_2_intt_stage_ctrl.sv
// Sequencer for one radix-2 INTT stage: issues LEN/2 butterflies, runs them
// through the PE and writes the halved results back in place two cycles later.
module radix_2_intt_stage_ctrl
    import radix_2_intt_stage_ctrl_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int Q       = Q_DEF,
    parameter int TWOINV  = TWOINV_DEF,
    parameter int LOG_LEN = LOG_LEN_DEF,
    parameter int SW      = SW_DEF
) (
    input  logic clk,
    input  logic rst,
    radix_2_intt_stage_ctrl_if.master bus
);

    localparam int KW       = LOG_LEN - 1;
    localparam int HALF_LEN = 1 << KW;

    state_t             state;
    state_t             state_nxt;
    logic [KW-1:0]      k;
    logic [SW-1:0]      stage_q;
    logic               issue;
    logic               busy;
    logic               done;
    logic               last_k;
    logic [31:0]        s;
    logic [LOG_LEN-1:0] kx;
    logic [LOG_LEN-1:0] half;
    logic [LOG_LEN-1:0] j;
    logic [LOG_LEN-1:0] addr_a;
    logic [LOG_LEN-1:0] addr_b;
    logic [KW-1:0]      tw_idx;
    logic [LOG_LEN-1:0] iss_a;
    logic [LOG_LEN-1:0] iss_b;
    logic [KW-1:0]      iss_tw;
    logic               v1;
    logic               v2;
    logic [LOG_LEN-1:0] a1;
    logic [LOG_LEN-1:0] b1;
    logic [LOG_LEN-1:0] a2;
    logic [LOG_LEN-1:0] b2;
    logic [N-1:0]       pe_a;
    logic [N-1:0]       pe_b;
    logic [N-1:0]       res_a;
    logic [N-1:0]       res_b;

    assign last_k = (k == KW'(HALF_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_k) state_nxt = DRAIN;
            DRAIN:   if (k == KW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue = (state == RUN);
        busy  = (state == RUN) || (state == DRAIN);
        done  = (state == DONE);
    end

    // k walks the butterflies in RUN, then is reused to time the two DRAIN cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= '0;
        end else if (issue) begin
            k <= last_k ? '0 : k + KW'(1);
        end else if (state == DRAIN) begin
            k <= k + KW'(1);
        end else begin
            k <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else if (state == IDLE && bus.start) begin
            stage_q <= SW'(clamp_stage(32'(bus.stage), LOG_LEN));
        end
    end

    always_comb begin
        s      = 32'(stage_q);
        kx     = LOG_LEN'(k);
        half   = LOG_LEN'(1) << s;
        j      = kx & (half - LOG_LEN'(1));
        addr_a = ((kx >> s) << (s + 32'd1)) + j;
        addr_b = addr_a + half;
        tw_idx = KW'(j << (32'(KW) - s));
        iss_a  = issue ? addr_a : '0;
        iss_b  = issue ? addr_b : '0;
        iss_tw = issue ? tw_idx : '0;
    end

    radix_2_intt_pe #(
        .N      (N),
        .Q      (Q),
        .TWOINV (TWOINV)
    ) u_pe (
        .an    (bus.rd_data_a),
        .bn    (bus.rd_data_b),
        .tf    (bus.tw_data),
        .a_out (pe_a),
        .b_out (pe_b)
    );

    // Two-deep valid/address delay line; PE results are captured while the
    // first stage holds a live butterfly so write data lines up with the addresses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            a1    <= '0;
            b1    <= '0;
            a2    <= '0;
            b2    <= '0;
            res_a <= '0;
            res_b <= '0;
        end else begin
            v1 <= issue;
            a1 <= iss_a;
            b1 <= iss_b;
            v2 <= v1;
            a2 <= a1;
            b2 <= b1;
            if (v1) begin
                res_a <= pe_a;
                res_b <= pe_b;
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.rd_addr_a = iss_a;
    assign bus.rd_addr_b = iss_b;
    assign bus.tw_addr   = iss_tw;
    assign bus.wr_en     = v2;
    assign bus.wr_addr_a = a2;
    assign bus.wr_addr_b = b2;
    assign bus.wr_data_a = res_a;
    assign bus.wr_data_b = res_b;

endmodule

// File: tb/tb_radix_2_intt_stage_ctrl.sv
// Scoreboard bench for the INTT stage sequencer: a behavioural RAM/ROM feeds the DUT,
// expected write-backs are queued at issue time and a negedge monitor checks them.
module tb_radix_2_intt_stage_ctrl;
    import radix_2_intt_stage_ctrl_pkg::*;

    localparam int  N      = 17;
    localparam int  LEN    = 16;
    localparam int  HALF   = 8;
    localparam longint Q      = 65537;
    localparam longint TWOINV = 32769;

    typedef struct {
        int     aa;
        int     ab;
        longint da;
        longint db;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    radix_2_intt_stage_ctrl_if bus ();

    radix_2_intt_stage_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [N-1:0] ram      [LEN];
    logic [N-1:0] rom      [HALF];
    logic [N-1:0] load_img [LEN];
    logic         load_req = 1'b0;
    longint       ref_mem  [LEN];
    longint       x_vec    [LEN];
    int           exp_a    [HALF];
    int           exp_b    [HALF];
    int           exp_t    [HALF];
    wr_t          write_q  [$];

    int tests       = 0;
    int fails       = 0;
    int done_count  = 0;
    int write_count = 0;
    bit check_writes = 1'b1;

    // Synchronous-read memories; the bench only loads RAM through this process.
    always @(posedge clk) begin
        bus.rd_data_a <= ram[bus.rd_addr_a];
        bus.rd_data_b <= ram[bus.rd_addr_b];
        bus.tw_data   <= rom[bus.tw_addr];
        if (load_req) begin
            for (int i = 0; i < LEN; i++) ram[i] = load_img[i];
        end else if (bus.wr_en) begin
            ram[bus.wr_addr_a] = bus.wr_data_a;
            ram[bus.wr_addr_b] = bus.wr_data_b;
        end
    end

    task automatic checkOutput(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (bus.done) done_count++;
        if (bus.wr_en && !rst) begin
            write_count++;
            if (check_writes) begin
                if (write_q.size() == 0) begin
                    checkOutput("unexpected_write", 1, 0);
                end else begin
                    e = write_q.pop_front();
                    checkOutput("wr_addr_a", bus.wr_addr_a, e.aa);
                    checkOutput("wr_addr_b", bus.wr_addr_b, e.ab);
                    checkOutput($sformatf("wr_data_a@%0d", e.aa), bus.wr_data_a, e.da);
                    checkOutput($sformatf("wr_data_b@%0d", e.ab), bus.wr_data_b, e.db);
                end
            end
        end
    end

    function automatic longint modq(input longint v);
        return ((v % Q) + Q) % Q;
    endfunction

    function automatic longint modpow(input longint b, input int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = modq(r * b);
        return r;
    endfunction

    task automatic loadMemory();
        for (int i = 0; i < LEN; i++) begin
            load_img[i] = N'(ref_mem[i]);
        end
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Queue expected write-backs and issue addresses for stage s, and advance the reference memory.
    task automatic pushStage(input int s);
        int     h;
        int     grp;
        int     j;
        int     a;
        int     b;
        longint w;
        wr_t    e;
        h = 1 << s;
        for (int k = 0; k < HALF; k++) begin
            grp = k / h;
            j   = k % h;
            a   = grp * 2 * h + j;
            b   = a + h;
            w   = rom[j * (HALF / h)];
            exp_a[k] = a;
            exp_b[k] = b;
            exp_t[k] = j * (HALF / h);
            e.aa = a;
            e.ab = b;
            e.da = modq((ref_mem[a] + ref_mem[b]) * TWOINV);
            e.db = modq(modq(modq(ref_mem[a] - ref_mem[b]) * w) * TWOINV);
            ref_mem[a] = e.da;
            ref_mem[b] = e.db;
            write_q.push_back(e);
        end
    endtask

    // Starts a stage at the current negedge and follows it cycle by cycle until done.
    task automatic applyStimulus(input int s, input bit noise);
        int d0;
        int w0;
        int cyc;
        bit seen;
        d0 = done_count;
        w0 = write_count;
        bus.start = 1'b1;
        bus.stage = 2'(s);
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < HALF; c++) begin
            checkOutput($sformatf("rd_addr_a s%0d k%0d", s, c), bus.rd_addr_a, exp_a[c]);
            checkOutput($sformatf("rd_addr_b s%0d k%0d", s, c), bus.rd_addr_b, exp_b[c]);
            checkOutput($sformatf("tw_addr s%0d k%0d", s, c), bus.tw_addr, exp_t[c]);
            checkOutput($sformatf("busy cyc%0d", c + 1), bus.busy, 1);
            checkOutput($sformatf("wr_en cyc%0d", c + 1), bus.wr_en, (c >= 2) ? 1 : 0);
            bus.start = noise && (c == 3);
            @(negedge clk);
        end
        bus.start = 1'b0;
        seen = 1'b0;
        cyc  = HALF + 1;
        while (!seen && cyc < HALF + 12) begin
            if (bus.done) begin
                seen = 1'b1;
                checkOutput("done_cycle", cyc, HALF + 3);
                checkOutput("busy_during_done", bus.busy, 0);
                if (noise) bus.start = 1'b1;
            end else if (cyc <= HALF + 2) begin
                checkOutput($sformatf("drain wr_en cyc%0d", cyc), bus.wr_en, 1);
                checkOutput($sformatf("drain busy cyc%0d", cyc), bus.busy, 1);
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        checkOutput("done_seen", seen, 1);
        @(negedge clk);
        checkOutput("idle_after_done", bus.busy, 0);
        checkOutput("done_pulses", done_count - d0, 1);
        checkOutput("write_count", write_count - w0, HALF);
        checkOutput("queue_drained", write_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int tr2a[HALF] = '{0, 1, 2, 3, 8, 9, 10, 11};
        int tr2t[HALF] = '{0, 2, 4, 6, 0, 2, 4, 6};
        longint omega;
        longint t;
        longint ua;
        int h;
        int a;
        int b;
        int d0;

        bus.start = 1'b0;
        bus.stage = '0;
        for (int i = 0; i < HALF; i++) rom[i] = 1;
        for (int i = 0; i < LEN; i++) ref_mem[i] = i;
        #1;
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset done", bus.done, 0);
        checkOutput("reset wr_en", bus.wr_en, 0);
        checkOutput("reset rd_addr_a", bus.rd_addr_a, 0);
        checkOutput("reset tw_addr", bus.tw_addr, 0);
        checkOutput("reset wr_data_a", bus.wr_data_a, 0);
        @(negedge clk);
        loadMemory();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a stage: outputs collapse at once, no done pulse follows.
        check_writes = 1'b0;
        d0 = done_count;
        bus.start = 1'b1;
        bus.stage = 2'd1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midrun wr_en before reset", bus.wr_en, 1);
        rst = 1'b1;
        #1;
        checkOutput("midrun wr_en after reset", bus.wr_en, 0);
        checkOutput("midrun busy after reset", bus.busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midrun no done", done_count - d0, 0);
        checkOutput("midrun idle", bus.busy, 0);
        check_writes = 1'b1;

        // Stage 0 on RAM[i]=i with unit twiddles.
        for (int i = 0; i < LEN; i++) ref_mem[i] = i;
        loadMemory();
        pushStage(0);
        applyStimulus(0, 1'b0);
        checkOutput("stage0 ram[0]", ram[0], 32769);
        checkOutput("stage0 ram[1]", ram[1], 32768);
        checkOutput("stage0 ram[2]", ram[2], 32771);
        checkOutput("stage0 ram[3]", ram[3], 32768);

        // Stage 2 against the hand-written address trace.
        pushStage(2);
        for (int k = 0; k < HALF; k++) begin
            exp_a[k] = tr2a[k];
            exp_b[k] = tr2a[k] + 4;
            exp_t[k] = tr2t[k];
        end
        applyStimulus(2, 1'b0);

        // Stage 3: pairs (j, j+8), twiddle index j.
        pushStage(3);
        for (int k = 0; k < HALF; k++) begin
            exp_a[k] = k;
            exp_b[k] = k + 8;
            exp_t[k] = k;
        end
        applyStimulus(3, 1'b0);

        // Spurious start pulses while busy and while done must be ignored.
        pushStage(1);
        applyStimulus(1, 1'b1);

        // Full round trip: forward NTT in the bench, four DUT stages must restore the input.
        omega = modpow(3, 4096);
        for (int i = 0; i < HALF; i++) rom[i] = N'(modpow(modpow(omega, 15), i));
        for (int i = 0; i < LEN; i++) begin
            x_vec[i]   = longint'($urandom_range(0, 65536));
            ref_mem[i] = x_vec[i];
        end
        for (int s = 3; s >= 0; s--) begin
            h = 1 << s;
            for (int k = 0; k < HALF; k++) begin
                a  = (k / h) * 2 * h + (k % h);
                b  = a + h;
                t  = modq(ref_mem[b] * modpow(omega, (k % h) * (HALF / h)));
                ua = ref_mem[a];
                ref_mem[a] = modq(ua + t);
                ref_mem[b] = modq(ua - t);
            end
        end
        loadMemory();
        for (int s = 0; s < 4; s++) begin
            pushStage(s);
            applyStimulus(s, 1'b0);
        end
        for (int i = 0; i < LEN; i++) begin
            checkOutput($sformatf("roundtrip[%0d]", i), ram[i], x_vec[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
